// File: rtl/mux_sel_stepper.sv
// mux_sel_stepper: registered NUM_IN:1 multiplexer of WIDTH-bit channels.
// Debounced up/down/centre buttons or a direct load port set the select register.
module mux_sel_stepper #(
    parameter int NUM_IN    = 5,
    parameter int WIDTH     = 1,
    parameter int DB_CYCLES = 1000000,
    localparam int SEL_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] mux_in,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_center,
    input  logic                    load_en,
    input  logic [SEL_W-1:0]        load_sel,
    output logic [WIDTH-1:0]        mux_out,
    output logic [SEL_W-1:0]        sel_out,
    output logic                    sel_changed
);

    // The counter must be able to hold DB_CYCLES-1; toggling happens on the step
    // that would take it to DB_CYCLES.
    localparam int               CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_IN - 1);

    // Button index: 0 = up, 1 = down, 2 = centre.
    logic [2:0]       w_btn_raw;
    logic [2:0]       w_press;
    logic [SEL_W-1:0] w_sel_next;
    logic [WIDTH-1:0] w_chan [NUM_IN];
    logic [WIDTH-1:0] w_chan_sel;

    logic [SEL_W-1:0] r_sel;
    logic             r_sel_changed;
    logic [WIDTH-1:0] r_mux;

    assign w_btn_raw = {btn_center, btn_down, btn_up};

    genvar gi;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic             r_stable_prev;
            logic [CNT_W-1:0] r_cnt;

            // Synchronise the raw button, then require DB_CYCLES consecutive
            // disagreeing samples before the stable state flips.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync1       <= 1'b0;
                    r_sync2       <= 1'b0;
                    r_stable      <= 1'b0;
                    r_stable_prev <= 1'b0;
                    r_cnt         <= '0;
                end else begin
                    r_sync1       <= w_btn_raw[gi];
                    r_sync2       <= r_sync1;
                    r_stable_prev <= r_stable;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_stable <= ~r_stable;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Rising edge of the debounced state only; releases are silent.
            assign w_press[gi] = r_stable & ~r_stable_prev;
        end

        for (gi = 0; gi < NUM_IN; gi++) begin : g_chan
            assign w_chan[gi] = mux_in[gi*WIDTH +: WIDTH];
        end

        if (NUM_IN == 1) begin : g_single
            assign w_chan_sel = w_chan[0];
        end else begin : g_multi
            assign w_chan_sel = w_chan[r_sel];
        end
    endgenerate

    // Next select: load beats centre beats up/down; conflicting up+down cancel.
    always_comb begin
        w_sel_next = r_sel;
        if (load_en) begin
            if (load_sel <= SEL_MAX) begin
                w_sel_next = load_sel;
            end
        end else if (w_press[2]) begin
            w_sel_next = '0;
        end else if (w_press[0] && w_press[1]) begin
            w_sel_next = r_sel;
        end else if (w_press[0]) begin
            w_sel_next = (r_sel == SEL_MAX) ? '0 : r_sel + 1'b1;
        end else if (w_press[1]) begin
            w_sel_next = (r_sel == '0) ? SEL_MAX : r_sel - 1'b1;
        end
    end

    // Select register with a change pulse aligned to the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel         <= '0;
            r_sel_changed <= 1'b0;
        end else begin
            r_sel         <= w_sel_next;
            r_sel_changed <= (w_sel_next != r_sel);
        end
    end

    // Output register: one cycle behind both mux_in and the select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mux <= '0;
        end else begin
            r_mux <= w_chan_sel;
        end
    end

    assign mux_out     = r_mux;
    assign sel_out     = r_sel;
    assign sel_changed = r_sel_changed;

endmodule

// File: doc/mux_sel_stepper.md
Name: mux_sel_stepper

Overview:
- Parametrised, registered NUM_IN:1 multiplexer of WIDTH-bit channels.
- The select is held in a register. Debounced board buttons step it up or down with wrap-around, the centre button homes it to channel 0, and a direct load port can also set it.
- Sits between board-level sources and display/LED logic. It is the clocked, generalised replacement for the fixed 5:1 single-bit combinational mux.

Parameters:
- NUM_IN, 5, number of input channels (>=1).
- WIDTH, 1, bits per channel.
- DB_CYCLES, 1000000, consecutive stable cycles for a button to register (10 ms at 100 MHz; >=1).
- Derived, not overridable: SEL_W = max(1, $clog2(NUM_IN)).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mux_in  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- btn_up  in  1  raw asynchronous button: step select +1.
- btn_down  in  1  raw asynchronous button: step select -1.
- btn_center  in  1  raw asynchronous button: select := 0.
- load_en  in  1  synchronous load strobe.
- load_sel  in  SEL_W  select value applied when load_en=1.
- mux_out  out  WIDTH  registered selected channel.
- sel_out  out  SEL_W  current select register.
- sel_changed  out  1  one-cycle pulse when sel_out takes a different value.

Behaviour:
- Reset (rst=1 at an edge):
  - sel_out=0, mux_out=0, sel_changed=0.
  - All synchroniser flops, debounced-stable states and debounce counters are cleared to 0.
  - Reset has priority over every other input.
- Button path, identical for each of the three buttons:
  - 2-flop synchroniser feeds sync2.
  - Debounce counter increments at each edge where sync2 != stable, and clears to 0 at any edge where sync2 == stable.
  - When the counter would reach DB_CYCLES, stable toggles and the counter clears.
  - press = stable & ~stable_prev, one cycle wide. Release edges generate nothing.
- Button timing:
  - If a button is first sampled high at edge k and held, stable rises after edge k+1+DB_CYCLES.
  - sel_out updates at edge k+2+DB_CYCLES.
  - mux_out reflects the new channel at edge k+3+DB_CYCLES.
  - High pulses seen by sync2 for fewer than DB_CYCLES consecutive edges are ignored.
  - A button held indefinitely produces exactly one press; there is no auto-repeat.
  - A button held across reset release registers one press after the full debounce time.
- Select update priority, evaluated per edge:
  1. load_en: if load_sel < NUM_IN, sel := load_sel. If load_sel >= NUM_IN, the load is ignored and sel is unchanged. Either way, all presses in that cycle are discarded.
  2. Centre press: sel := 0.
  3. Up press and down press in the same cycle: no change.
  4. Up press: sel := (sel == NUM_IN-1) ? 0 : sel+1.
  5. Down press: sel := (sel == 0) ? NUM_IN-1 : sel-1.
- sel_changed:
  - Registered. High for exactly the cycle in which sel_out first shows the new value.
  - Only asserted when the new value differs from the old: a load of the current value gives no pulse, and neither does centre at 0.
- Output path:
  - mux_out at edge t+1 = channel[sel_out at t], so there is 1 cycle of latency from a mux_in change or a sel_out change.
  - No combinational path from any input to any output.
- NUM_IN=1: sel_out is fixed at 0, sel_changed never asserts, and mux_out registers channel 0.
- Reset mid-debounce: the partial count is lost. After release, a fresh DB_CYCLES of stable high is required.

Test Plan (NUM_IN=5, WIDTH=8, DB_CYCLES=4):
- Reset and output latency:
  - rst=1 for 3 cycles with mux_in = 40'h44_33_22_11_A5 -> mux_out=0, sel_out=0, sel_changed=0.
  - After release -> mux_out=8'hA5 one edge later.
  - Change channel 0 to 8'h5A -> mux_out=8'h5A exactly 1 edge later.
- Debounce timing:
  - btn_up first sampled high at edge k, held 12 cycles -> sel_out=1 and sel_changed=1 at edge k+6, mux_out=8'h11 at edge k+7.
  - No further change for the remainder of the hold or on release.
- Glitch rejection:
  - btn_up high for 3 cycles -> sel_out unchanged, no sel_changed.
  - btn_down toggling every cycle for 20 cycles -> no change.
- Wrap-around:
  - From sel 0, five up presses -> sel_out 1,2,3,4,0, with a sel_changed pulse on each.
  - From 0, one down press -> 4, mux_out=8'h44.
- Load priority and invalid load:
  - load_en=1, load_sel=3 in the same cycle as an up press -> sel_out=3.
  - load_sel=6 -> sel_out unchanged, no pulse.
  - load_sel=3 while sel_out=3 -> no pulse.
  - Centre press while at 3 -> sel_out=0.
- Simultaneous presses and reset mid-operation:
  - Up and down presses landing in the same cycle -> no change, no pulse.
  - btn_up held 3 cycles, then rst for 1 cycle while btn_up stays high -> no change before the full debounce (rst release + 6 edges) completes, then exactly one increment.
